twos_to_sign_mag: RTL

TWOS_TO_SIGN_MAG -- requirements
Module: twos_to_sign_mag

---
 rtl/twos_to_sign_mag.sv | 116 +++++++++++
 1 files changed

// File: rtl/twos_to_sign_mag.sv
// Serial two's-complement to signed-magnitude converter: one magnitude bit per
// cycle, LSB first, with negation done on the fly via a seen-one flag.
module twos_to_sign_mag #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ovf,
    output logic         busy
);

    localparam int unsigned MW = N - 1;
    localparam int unsigned CW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 2);
    localparam logic [N-1:0]  MOST_NEG = {1'b1, {MW{1'b0}}};
    localparam logic [N-1:0]  SAT_NEG  = {1'b1, {MW{1'b1}}};

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t          state, state_d;
    logic            sign, sign_d;
    logic [MW-1:0]   shreg, shreg_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            seen_one, seen_d;
    logic [N-1:0]    out_data_d;
    logic            out_valid_d, ovf_d, in_ready_d, busy_d;
    logic            bit_in, bit_out;
    logic [MW-1:0]   mag_next;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            seen_one  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            sign      <= sign_d;
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            seen_one  <= seen_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_ovf   <= ovf_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        sign_d      = sign;
        shreg_d     = shreg;
        cnt_d       = cnt;
        seen_d      = seen_one;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        ovf_d       = out_ovf;

        // Bits after the first 1 of a negative word are inverted
        bit_in   = shreg[0];
        bit_out  = (sign && seen_one) ? ~bit_in : bit_in;
        mag_next = shreg >> 1;
        mag_next[MW-1] = bit_out;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CONV;
                    sign_d   = in_data[N-1];
                    shreg_d  = in_data[N-2:0];
                    cnt_d    = '0;
                    seen_d   = 1'b0;
                    ovf_d    = (in_data == MOST_NEG);
                end
            end
            CONV: begin
                shreg_d = mag_next;
                seen_d  = seen_one | bit_in;
                if (cnt == LAST_BIT) begin
                    cnt_d       = '0;
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                    out_data_d  = out_ovf ? SAT_NEG : {sign, mag_next};
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

endmodule
